patgen: RTL and testbench

PATGEN -- requirements
Module: patgen

---
 rtl/patgen.sv | 142 ++++++++++++++
 tb/tb_patgen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/patgen.sv
// Colour-bar test pattern generator with VGA/XGA/SXGA raster timing.
// Outputs are registered and lag the raster counters by one cycle.
module patgen_syncgen (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  resol_i,
  output logic [10:0] HSC,
  output logic [10:0] VSC,
  output logic        frame_start_o,
  output logic        active_o,
  output logic        hsync_x_o,
  output logic        vsync_x_o,
  output logic [2:0]  bar_o
);
  logic [10:0] hact, hs_beg, hs_end, vact, vs_beg, vs_end, barw;
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;

  // resol_i is pre-normalised: 0 VGA, 1 XGA, 2 SXGA
  always_comb begin
    case (resol_i)
      2'd1: begin
        hact = 11'd1024; hs_beg = 11'd1048; hs_end = 11'd1184; HSC = 11'd1344;
        vact = 11'd768;  vs_beg = 11'd771;  vs_end = 11'd777;  VSC = 11'd806;
        barw = 11'd128;
      end
      2'd2: begin
        hact = 11'd1280; hs_beg = 11'd1328; hs_end = 11'd1440; HSC = 11'd1688;
        vact = 11'd1024; vs_beg = 11'd1025; vs_end = 11'd1028; VSC = 11'd1066;
        barw = 11'd160;
      end
      default: begin
        hact = 11'd640;  hs_beg = 11'd656;  hs_end = 11'd752;  HSC = 11'd800;
        vact = 11'd480;  vs_beg = 11'd490;  vs_end = 11'd492;  VSC = 11'd525;
        barw = 11'd80;
      end
    endcase
  end

  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q >= HSC - 11'd1) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q >= VSC - 11'd1) ? 11'd0 : vcnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Bar index is the number of bar boundaries already passed on this line
  always_comb begin
    bar_o = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt_q >= 11'(k) * barw) bar_o = 3'(k);
    end
  end

  assign frame_start_o = (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
  assign active_o      = (hcnt_q < hact) && (vcnt_q < vact);
  assign hsync_x_o     = !((hcnt_q >= hs_beg) && (hcnt_q < hs_end));
  assign vsync_x_o     = !((vcnt_q >= vs_beg) && (vcnt_q < vs_end));
endmodule

module patgen (
  input  logic       DCLK,
  input  logic       ARESETN,
  input  logic [1:0] RESOL,
  output logic       DSP_HSYNC_X,
  output logic       DSP_VSYNC_X,
  output logic       DSP_DE,
  output logic [7:0] DSP_R,
  output logic [7:0] DSP_G,
  output logic [7:0] DSP_B
);
  logic [1:0]  resol_in, resol_q, resol_d;
  logic [10:0] hsc, vsc;
  logic        frame_start, active, hsync_x, vsync_x;
  logic [2:0]  bar;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  assign resol_in = (RESOL == 2'b11) ? 2'b00 : RESOL;

  patgen_syncgen syncgen (
    .clk_i         (DCLK),
    .rst_n_i       (ARESETN),
    .resol_i       (resol_q),
    .HSC           (hsc),
    .VSC           (vsc),
    .frame_start_o (frame_start),
    .active_o      (active),
    .hsync_x_o     (hsync_x),
    .vsync_x_o     (vsync_x),
    .bar_o         (bar)
  );

  // Bar colour bits: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars
  always_comb begin
    resol_d = resol_q;
    if (!ARESETN || frame_start) resol_d = resol_in;
    de_d = active;
    hs_d = hsync_x;
    vs_d = vsync_x;
    r_d  = (active && !bar[1]) ? 8'hFF : 8'h00;
    g_d  = (active && !bar[2]) ? 8'hFF : 8'h00;
    b_d  = (active && !bar[0]) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge DCLK) begin
    resol_q <= resol_d;
    if (!ARESETN) begin
      de_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      r_q  <= 8'h00;
      g_q  <= 8'h00;
      b_q  <= 8'h00;
    end else begin
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign DSP_DE      = de_q;
  assign DSP_HSYNC_X = hs_q;
  assign DSP_VSYNC_X = vs_q;
  assign DSP_R       = r_q;
  assign DSP_G       = g_q;
  assign DSP_B       = b_q;
endmodule

// File: tb/tb_patgen.sv
// Self-checking bench for patgen: resolution table, reset/RESOL corner sequences, random run vs raster model.
module tb_patgen;
  logic       DCLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic [1:0] RESOL = 2'b00;
  logic       DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE;
  logic [7:0] DSP_R, DSP_G, DSP_B;

  patgen dut (
    .DCLK        (DCLK),
    .ARESETN     (ARESETN),
    .RESOL       (RESOL),
    .DSP_HSYNC_X (DSP_HSYNC_X),
    .DSP_VSYNC_X (DSP_VSYNC_X),
    .DSP_DE      (DSP_DE),
    .DSP_R       (DSP_R),
    .DSP_G       (DSP_G),
    .DSP_B       (DSP_B)
  );

  always #5 DCLK = ~DCLK;

  typedef struct packed {
    logic        de;
    logic        hs_x;
    logic        vs_x;
    logic [23:0] rgb;
  } vid_t;

  typedef struct {
    logic [1:0] resol;
    int         hsc;
    int         vsc;
    int         barw;
    int         hact;
    int         hs_start;
    int         hs_width;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int unsigned H_ACT [3] = '{640, 1024, 1280};
  int unsigned H_FP  [3] = '{16, 24, 48};
  int unsigned H_SW  [3] = '{96, 136, 112};
  int unsigned H_TOT [3] = '{800, 1344, 1688};
  int unsigned V_ACT [3] = '{480, 768, 1024};
  int unsigned V_FP  [3] = '{10, 3, 1};
  int unsigned V_SW  [3] = '{2, 6, 3};
  int unsigned V_TOT [3] = '{525, 806, 1066};
  logic [23:0] BARS  [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int unsigned m_pix = 0;
  int          m_res = 0;
  vid_t        got, exp_v;
  vid_t        line[$];
  vec_t        vecs[4];

  function automatic int norm(input logic [1:0] r);
    return (r == 2'b11) ? 0 : int'(r);
  endfunction

  // Expected outputs for linear frame position pix at resolution r
  function automatic vid_t pixel(input int unsigned pix, input int r);
    int unsigned x, y;
    vid_t v;
    x = pix % H_TOT[r];
    y = pix / H_TOT[r];
    v.de   = (x < H_ACT[r]) && (y < V_ACT[r]);
    v.hs_x = !((x >= H_ACT[r] + H_FP[r]) && (x < H_ACT[r] + H_FP[r] + H_SW[r]));
    v.vs_x = !((y >= V_ACT[r] + V_FP[r]) && (y < V_ACT[r] + V_FP[r] + V_SW[r]));
    v.rgb  = 24'h000000;
    if (v.de) v.rgb = BARS[x / (H_ACT[r] / 8)];
    return v;
  endfunction

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_vid(input string name, input vid_t act, input vid_t req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s @%0t: got de=%b hs=%b vs=%b rgb=%h expected de=%b hs=%b vs=%b rgb=%h",
               name, $time, act.de, act.hs_x, act.vs_x, act.rgb,
               req.de, req.hs_x, req.vs_x, req.rgb);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare on the falling edge
  task automatic tick(input logic rn, input logic [1:0] rs);
    ARESETN = rn;
    RESOL   = rs;
    @(posedge DCLK);
    if (!rn) begin
      m_pix = 0;
      m_res = norm(rs);
      exp_v = {1'b0, 1'b1, 1'b1, 24'h000000};
    end else begin
      if (m_pix == 0) m_res = norm(rs);
      exp_v = pixel(m_pix, m_res);
      m_pix = (m_pix + 1) % (H_TOT[m_res] * V_TOT[m_res]);
    end
    @(negedge DCLK);
    got = {DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X, DSP_R, DSP_G, DSP_B};
    check_vid("cycle", got, exp_v);
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, rst_len;
    logic [1:0] cur_res;

    vecs[0] = '{2'b00, 800, 525, 80, 640, 656, 96};
    vecs[1] = '{2'b01, 1344, 806, 128, 1024, 1048, 136};
    vecs[2] = '{2'b10, 1688, 1066, 160, 1280, 1328, 112};
    vecs[3] = '{2'b11, 800, 525, 80, 640, 656, 96};

    // Per-resolution first line: counts, sync placement and bar edges
    for (int i = 0; i < 4; i++) begin
      repeat (3) tick(1'b0, vecs[i].resol);
      check_int("reset_de", int'(DSP_DE), 0);
      check_int("reset_hsync", int'(DSP_HSYNC_X), 1);
      line.delete();
      for (int c = 0; c < vecs[i].hsc + 2; c++) begin
        tick(1'b1, vecs[i].resol);
        line.push_back(got);
      end
      check_int("HSC", int'(dut.syncgen.HSC), vecs[i].hsc);
      check_int("VSC", int'(dut.syncgen.VSC), vecs[i].vsc);
      de_cnt = 0; hs_cnt = 0; hs_first = -1;
      for (int c = 0; c < vecs[i].hsc; c++) begin
        if (line[c].de) de_cnt++;
        if (!line[c].hs_x) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = c;
        end
      end
      check_int("line_de_count", de_cnt, vecs[i].hact);
      check_int("hsync_start", hs_first, vecs[i].hs_start);
      check_int("hsync_width", hs_cnt, vecs[i].hs_width);
      check_int("first_pixel", int'(line[0].rgb), int'(BARS[0]));
      check_int("bar0_last", int'(line[vecs[i].barw - 1].rgb), int'(BARS[0]));
      check_int("bar1_first", int'(line[vecs[i].barw].rgb), int'(BARS[1]));
      check_int("bar6_last", int'(line[vecs[i].barw * 7 - 1].rgb), int'(BARS[6]));
      check_int("bar7_de", int'(line[vecs[i].barw * 7].de), 1);
      check_int("bar7_black", int'(line[vecs[i].barw * 7].rgb), 0);
      check_int("blank_de", int'(line[vecs[i].hact].de), 0);
      check_int("line1_start", int'(line[vecs[i].hsc].rgb), int'(BARS[0]));
    end

    // Reset held 4 cycles mid-line restarts the frame at pixel (0,0)
    repeat (2) tick(1'b0, 2'b00);
    repeat (300) tick(1'b1, 2'b00);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 2'b00);
      check_int("midrst_de", int'(DSP_DE), 0);
      check_int("midrst_rgb", int'({DSP_R, DSP_G, DSP_B}), 0);
    end
    tick(1'b1, 2'b00);
    check_int("release_de", int'(DSP_DE), 1);
    check_int("release_rgb", int'({DSP_R, DSP_G, DSP_B}), 24'hFFFFFF);
    de_cnt = 0;
    for (int c = 0; c < 799; c++) begin
      tick(1'b1, 2'b00);
      if (got.de) de_cnt++;
    end
    check_int("release_line_de", de_cnt, 639);

    // RESOL changed mid-frame keeps VGA timing for the rest of the frame
    repeat (2) tick(1'b0, 2'b00);
    repeat (100) tick(1'b1, 2'b00);
    de_cnt = 0; hs_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      tick(1'b1, 2'b10);
      if (got.de) de_cnt++;
      if (!got.hs_x) hs_cnt++;
    end
    check_int("midframe_de", de_cnt, 540 + 640);
    check_int("midframe_hs", hs_cnt, 192);
    check_int("midframe_HSC", int'(dut.syncgen.HSC), 800);

    // Random resets and RESOL changes against the model
    cur_res = 2'($urandom_range(0, 3));
    rst_len = 3;
    for (int c = 0; c < 40000; c++) begin
      if (rst_len == 0 && $urandom_range(0, 2999) == 0) rst_len = $urandom_range(1, 6);
      if ($urandom_range(0, 1999) == 0) cur_res = 2'($urandom_range(0, 3));
      if (rst_len > 0) begin
        tick(1'b0, cur_res);
        rst_len--;
      end else begin
        tick(1'b1, cur_res);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
